// File: rtl/mul_progressive_iter.sv
// ---------------------------------------------------------------------------
// mul_progressive_iter
//
// Iterative signed fixed-point multiplier with a runtime precision mode.
// Operand b is consumed DIGIT bits per cycle, least significant digit first,
// so low-precision products finish in fewer cycles than full-precision ones.
//
// Precision P is chosen per operation by 'mode':
//   mode 0 -> P = WIDTH/4, mode 1 -> P = WIDTH/2, mode 2/3 -> P = WIDTH
// Only a[P-1:0] and b[P-1:0] take part; both are signed Q0.(P-1).
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   in_valid     operand valid
//   in_ready     block can accept operands (combinational from state, out_ready)
//   mode         precision select
//   a, b         multiplicand / multiplier
//   tag          user tag, returned with the result
//   out_valid    result valid
//   out_ready    consumer accepts result
//   prod_full    2P-bit product Q1.(2P-2), sign-extended to 2*WIDTH
//   prod_aligned prod_full << 2*(WIDTH-P), i.e. Q1.(2*WIDTH-2)
//   out_mode     mode of the result (3 reported as 2)
//   out_tag      tag of the result
//   busy         high while digits are being processed
// ---------------------------------------------------------------------------
module mul_progressive_iter #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TAG_W-1:0]     tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod_full,
    output logic [2*WIDTH-1:0]   prod_aligned,
    output logic [1:0]           out_mode,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int P0    = WIDTH / 4;
    localparam int P1    = WIDTH / 2;
    localparam int P2    = WIDTH;
    localparam int NMAX  = WIDTH / DIGIT;
    localparam int K_W   = (NMAX > 1) ? $clog2(NMAX) : 1;

    // Index of the final (signed) digit for each precision.
    localparam logic [K_W-1:0] LAST0 = K_W'(P0 / DIGIT - 1);
    localparam logic [K_W-1:0] LAST1 = K_W'(P1 / DIGIT - 1);
    localparam logic [K_W-1:0] LAST2 = K_W'(P2 / DIGIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   a_ext;
    logic        [WIDTH-1:0]   b_reg;
    logic        [1:0]         mode_reg;
    logic        [TAG_W-1:0]   tag_reg;
    logic signed [ACC_W-1:0]   acc;
    logic        [K_W-1:0]     k;

    logic                      accept;
    logic        [1:0]         mode_norm;
    logic signed [ACC_W-1:0]   a_sext_in;
    logic        [K_W-1:0]     last_k;
    logic                      is_last;
    logic        [DIGIT-1:0]   digit_raw;
    logic signed [ACC_W-1:0]   digit_ext;
    logic signed [ACC_W-1:0]   pp;
    logic signed [ACC_W-1:0]   acc_next;
    logic        [ACC_W-1:0]   aligned_next;

    // A new operation can start from IDLE, or from DONE in the same cycle
    // the consumer takes the pending result.
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    // Input-side decode: fold mode 3 onto mode 2 and sign-extend the
    // active slice of a to the full accumulator width once, at accept time,
    // so the per-digit datapath never has to look at the mode for a.
    always_comb begin
        mode_norm = (mode == 2'd3) ? 2'd2 : mode;
        case (mode_norm)
            2'd0:    a_sext_in = {{(ACC_W - P0){a[P0-1]}}, a[P0-1:0]};
            2'd1:    a_sext_in = {{(ACC_W - P1){a[P1-1]}}, a[P1-1:0]};
            default: a_sext_in = {{(ACC_W - P2){a[P2-1]}}, a[P2-1:0]};
        endcase
    end

    // Per-digit datapath. Every digit except the top one is an unsigned
    // magnitude; the top digit carries the sign of b, so it is
    // sign-extended. Working modulo 2^ACC_W keeps the 2P-bit product
    // correctly sign-extended without any saturation logic.
    always_comb begin
        case (mode_reg)
            2'd0:    last_k = LAST0;
            2'd1:    last_k = LAST1;
            default: last_k = LAST2;
        endcase
        is_last   = (k == last_k);
        digit_raw = DIGIT'(b_reg >> (DIGIT * k));
        if (is_last) begin
            digit_ext = $signed({{(ACC_W - DIGIT){digit_raw[DIGIT-1]}}, digit_raw});
        end else begin
            digit_ext = $signed({{(ACC_W - DIGIT){1'b0}}, digit_raw});
        end
        pp       = a_ext * digit_ext;
        acc_next = acc + (pp <<< (DIGIT * k));
        case (mode_reg)
            2'd0:    aligned_next = acc_next << (2 * (WIDTH - P0));
            2'd1:    aligned_next = acc_next << (2 * (WIDTH - P1));
            default: aligned_next = acc_next << (2 * (WIDTH - P2));
        endcase
    end

    // Control FSM and all registered outputs. The accept block at the end
    // overrides the state chosen by the case statement; that only happens in
    // IDLE or DONE (in_ready is low in BUSY), which gives the back-to-back
    // DONE -> BUSY transition without a bubble through IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_ext        <= '0;
            b_reg        <= '0;
            mode_reg     <= '0;
            tag_reg      <= '0;
            acc          <= '0;
            k            <= '0;
            out_valid    <= 1'b0;
            prod_full    <= '0;
            prod_aligned <= '0;
            out_mode     <= '0;
            out_tag      <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                BUSY: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    if (is_last) begin
                        prod_full    <= acc_next;
                        prod_aligned <= aligned_next;
                        out_mode     <= mode_reg;
                        out_tag      <= tag_reg;
                        out_valid    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                a_ext    <= a_sext_in;
                b_reg    <= b;
                mode_reg <= mode_norm;
                tag_reg  <= tag;
                acc      <= '0;
                k        <= '0;
                busy     <= 1'b1;
                state    <= BUSY;
            end
        end
    end

endmodule

// File: tb/tb_mul_progressive_iter.sv
// ---------------------------------------------------------------------------
// tb_mul_progressive_iter
//
// Directed, table-driven bench for mul_progressive_iter at default
// parameters (WIDTH=16, DIGIT=4, TAG_W=4). Expected products were worked
// out by hand from signed(a_P) * signed(b_P). Hand-written sequences cover
// output backpressure with a simultaneous accept and reset during BUSY.
// ---------------------------------------------------------------------------
module tb_mul_progressive_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod_full;
    logic [31:0] prod_aligned;
    logic [1:0]  out_mode;
    logic [3:0]  out_tag;
    logic        busy;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [31:0] full;
        logic [31:0] aligned;
        logic [1:0]  omode;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    mul_progressive_iter #(
        .WIDTH (16),
        .DIGIT (4),
        .TAG_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode         (mode),
        .a            (a),
        .b            (b),
        .tag          (tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .prod_full    (prod_full),
        .prod_aligned (prod_aligned),
        .out_mode     (out_mode),
        .out_tag      (out_tag),
        .busy         (busy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one operation, wait (bounded) for in_ready, let it be taken at
    // the next edge, then scramble the operand pins so that any later use of
    // them by the DUT would corrupt the result. Returns #1 after the accept edge.
    task automatic applyStimulus(input vec_t v);
        int waited;
        mode     = v.mode;
        a        = v.a;
        b        = v.b;
        tag      = v.tag;
        in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~v.a;
        b        = ~v.b;
        tag      = ~v.tag;
        mode     = ~v.mode;
    endtask

    // Count edges until out_valid rises; -1 if it never does within budget.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t bp;
        vec_t ab;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'd0;
        a         = 16'h0;
        b         = 16'h0;
        tag       = 4'h0;

        //            mode  a         b         tag   prod_full      prod_aligned   omode lat
        vecs[0] = '{2'd2, 16'h4000, 16'h4000, 4'h1, 32'h10000000, 32'h10000000, 2'd2, 4};
        vecs[1] = '{2'd0, 16'hFFF8, 16'h0008, 4'h2, 32'h00000040, 32'h40000000, 2'd0, 1};
        vecs[2] = '{2'd1, 16'h00C0, 16'h0040, 4'hA, 32'hFFFFF000, 32'hF0000000, 2'd1, 2};
        vecs[3] = '{2'd2, 16'h8000, 16'h8000, 4'h3, 32'h40000000, 32'h40000000, 2'd2, 4};
        vecs[4] = '{2'd2, 16'h8000, 16'h7FFF, 4'h4, 32'hC0008000, 32'hC0008000, 2'd2, 4};
        vecs[5] = '{2'd2, 16'h0000, 16'h8000, 4'h5, 32'h00000000, 32'h00000000, 2'd2, 4};
        vecs[6] = '{2'd3, 16'hFFFF, 16'h0003, 4'h6, 32'hFFFFFFFD, 32'hFFFFFFFD, 2'd2, 4};
        vecs[7] = '{2'd1, 16'hAB7F, 16'hCD81, 4'h7, 32'hFFFFC0FF, 32'hC0FF0000, 2'd1, 2};
        vecs[8] = '{2'd0, 16'h0003, 16'h0002, 4'h8, 32'h00000006, 32'h06000000, 2'd0, 1};
        vecs[9] = '{2'd0, 16'hFFF7, 16'h1239, 4'h9, 32'hFFFFFFCF, 32'hCF000000, 2'd0, 1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid",    32'(out_valid), 32'd0);
        checkOutput("reset prod_full",    prod_full,      32'd0);
        checkOutput("reset prod_aligned", prod_aligned,   32'd0);
        checkOutput("reset out_mode",     32'(out_mode),  32'd0);
        checkOutput("reset out_tag",      32'(out_tag),   32'd0);
        checkOutput("reset busy",         32'(busy),      32'd0);
        checkOutput("reset in_ready",     32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors, consumer always ready.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d busy after accept", i),     32'(busy),     32'd1);
            checkOutput($sformatf("v%0d in_ready while busy", i),   32'(in_ready), 32'd0);
            waitResult(lat);
            checkOutput($sformatf("v%0d latency", i),      32'(lat),      32'(vecs[i].lat));
            checkOutput($sformatf("v%0d prod_full", i),    prod_full,     vecs[i].full);
            checkOutput($sformatf("v%0d prod_aligned", i), prod_aligned,  vecs[i].aligned);
            checkOutput($sformatf("v%0d out_mode", i),     32'(out_mode), 32'(vecs[i].omode));
            checkOutput($sformatf("v%0d out_tag", i),      32'(out_tag),  32'(vecs[i].tag));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d out_valid drop", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: result held for three cycles with a new op waiting,
        // then consumed and the new op accepted at the same edge.
        out_ready = 1'b0;
        bp = '{2'd2, 16'h4000, 16'h2000, 4'hC, 32'h08000000, 32'h08000000, 2'd2, 4};
        applyStimulus(bp);
        waitResult(lat);
        checkOutput("bp latency", 32'(lat), 32'd4);
        mode     = 2'd0;
        a        = 16'h0003;
        b        = 16'h0002;
        tag      = 4'h9;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold%0d out_valid", c),    32'(out_valid), 32'd1);
            checkOutput($sformatf("bp hold%0d prod_full", c),    prod_full,      32'h08000000);
            checkOutput($sformatf("bp hold%0d prod_aligned", c), prod_aligned,   32'h08000000);
            checkOutput($sformatf("bp hold%0d out_tag", c),      32'(out_tag),   32'hC);
            checkOutput($sformatf("bp hold%0d in_ready", c),     32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp in_ready on release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp out_valid after handoff", 32'(out_valid), 32'd0);
        checkOutput("bp busy after handoff",      32'(busy),      32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp next out_valid",    32'(out_valid), 32'd1);
        checkOutput("bp next prod_full",    prod_full,      32'h00000006);
        checkOutput("bp next prod_aligned", prod_aligned,   32'h06000000);
        checkOutput("bp next out_tag",      32'(out_tag),   32'h9);
        @(posedge clk);
        #1;

        // Reset during BUSY while digit k=2 of a mode-2 op is current.
        ab = '{2'd2, 16'h4000, 16'h4000, 4'h7, 32'h10000000, 32'h10000000, 2'd2, 4};
        applyStimulus(ab);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("abort out_valid",    32'(out_valid), 32'd0);
        checkOutput("abort prod_full",    prod_full,      32'd0);
        checkOutput("abort prod_aligned", prod_aligned,   32'd0);
        checkOutput("abort out_mode",     32'(out_mode),  32'd0);
        checkOutput("abort out_tag",      32'(out_tag),   32'd0);
        checkOutput("abort busy",         32'(busy),      32'd0);
        checkOutput("abort in_ready",     32'(in_ready),  32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("abort no result", 32'(seen), 32'd0);

        // Operation after the abort completes normally.
        applyStimulus(vecs[7]);
        waitResult(lat);
        checkOutput("post-abort latency",   32'(lat),      32'd2);
        checkOutput("post-abort prod_full", prod_full,     vecs[7].full);
        checkOutput("post-abort aligned",   prod_aligned,  vecs[7].aligned);
        checkOutput("post-abort out_tag",   32'(out_tag),  32'(vecs[7].tag));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_progressive_iter.md
Name: mul_progressive_iter

Overview:
- Iterative signed fixed-point multiplier with a runtime precision mode. It processes operand b DIGIT bits per cycle, LSB first.
- Supports three precisions, P = WIDTH/4, WIDTH/2 and WIDTH (Q0.3 / Q0.7 / Q0.15 at default). Low-precision operations finish in fewer cycles.
- Uses valid/ready handshakes on both sides. Outputs the product both native (sign-extended) and aligned to Q1.(2*WIDTH-2).
- Sits in the attention datapath as the area-efficient successor to the brute-force single-cycle multiplier.

Parameters:
- WIDTH, 16, max operand width; must be a multiple of 4.
- DIGIT, 4, bits of b consumed per cycle; must divide WIDTH/4.
- TAG_W, 4, width of the user tag carried from input to output.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- mode  in  2  precision select: 0 → P=WIDTH/4, 1 → P=WIDTH/2, 2 or 3 → P=WIDTH
- a  in  WIDTH  multiplicand; only a[P-1:0] used, signed Q0.(P-1)
- b  in  WIDTH  multiplier; only b[P-1:0] used, signed Q0.(P-1)
- tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- prod_full  out  2*WIDTH  2P-bit product Q1.(2P-2), sign-extended to 2*WIDTH
- prod_aligned  out  2*WIDTH  prod_full << 2*(WIDTH-P), i.e. Q1.(2*WIDTH-2)
- out_mode  out  2  mode of the result (3 reported as 2)
- out_tag  out  TAG_W  tag of the result
- busy  out  1  high in BUSY

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous active-low. Sampled low at a rising edge, it forces:
  - state=IDLE
  - out_valid=0, prod_full=0, prod_aligned=0, out_mode=0, out_tag=0, busy=0
  - accumulator and digit counter cleared
- Reset mid-operation aborts the operation; no result is ever emitted for it.
- FSM states: IDLE, BUSY, DONE.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only.
- On accept:
  - register a[P-1:0], b[P-1:0], mode and tag; later input changes are ignored.
  - clear the accumulator and set the digit counter to 0.
  - go to BUSY.
- BUSY, one digit per cycle, k = 0 .. N-1 with N = P/DIGIT (default N = 1, 2, 4 for modes 0, 1, 2):
  - acc += (sext(a_P) * d_k) << (DIGIT*k).
  - d_k is b_P[DIGIT*k +: DIGIT], taken unsigned for k<N-1 and signed for k=N-1.
  - The accumulator is 2P bits wide (2*WIDTH physical); no saturation is needed.
  - After digit N-1: register prod_full and prod_aligned, set out_valid=1, go to DONE.
- Latency: operands accepted at edge t → out_valid high after edge t+N.
- Exactness: result equals signed(a_P) × signed(b_P). -1×-1 gives +1.0, i.e. 2^(2P-2).
- DONE, out_valid=1:
  - all outputs are held stable until out_ready.
  - out_ready=1 without a new accept: out_valid→0, go to IDLE.
  - out_ready=1 with a simultaneous accept: start the new op and go directly to BUSY. out_valid deasserts at the same edge, so back-to-back throughput is one op per N+1 cycles.
- in_valid while BUSY has no effect; in_ready=0 then.
- mode=3 is processed identically to mode=2 and reported as 2.
- Bits of a and b above P-1 are ignored in all modes.

Test Plan:
- Mode 2, a=0x4000, b=0x4000 (0.5×0.5), out_ready=1 → out_valid 4 cycles after accept; prod_full=prod_aligned=0x10000000.
- Mode 0, a=0xFFF8, b=0x0008 (-1×-1, upper bits ignored) → latency 1; prod_full=0x00000040, prod_aligned=0x40000000.
- Mode 1, a=0x00C0, b=0x0040 (-0.5×0.5), tag=0xA → latency 2; prod_full=0xFFFFF000, prod_aligned=0xF0000000, out_tag=0xA, out_mode=1.
- Mode 2 corners:
  - 0x8000×0x8000 → 0x40000000.
  - 0x8000×0x7FFF → 0xC0008000.
  - 0x0000×0x8000 → 0x00000000.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → outputs and out_valid stable, in_ready=0. Then raise out_ready with in_valid=1 (mode 0, a=0x3, b=0x2) → accept in the same cycle; next prod_full=0x00000006 one cycle later.
- Drive rst_n=0 for 1 cycle in BUSY at k=2 of a mode 2 op → all outputs 0, state IDLE, in_ready=1. No out_valid occurs for the aborted op; the next op completes correctly.
